// File: rtl/cpu4_pkg.sv
// Shared types and constants for the 4-bit CPU multiply/divide sequencer.
package cpu4_pkg;

    localparam int DATA_W = 4;
    localparam int RES_W  = 2 * DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CALC  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Quotient reported alongside div_err when the divisor is zero.
    localparam logic [DATA_W-1:0] DIV0_QUOT = 4'hF;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the CPU control unit (master) and the sequencer (slave).
// res_zero/res_ovf exist only when ALU_MULDIV_FLAGS_EN is defined.
interface alu_muldiv_seq_if;

    logic                          start;
    logic                          op_sel;
    logic [cpu4_pkg::DATA_W-1:0]   operand_a;
    logic [cpu4_pkg::DATA_W-1:0]   operand_b;
    logic [cpu4_pkg::RES_W-1:0]    result;
    logic                          busy;
    logic                          done;
    logic                          div_err;
`ifdef ALU_MULDIV_FLAGS_EN
    logic                          res_zero;
    logic                          res_ovf;
`endif

    modport master (
        output start, op_sel, operand_a, operand_b,
`ifdef ALU_MULDIV_FLAGS_EN
        input  res_zero, res_ovf,
`endif
        input  result, busy, done, div_err
    );

    modport slave (
        input  start, op_sel, operand_a, operand_b,
`ifdef ALU_MULDIV_FLAGS_EN
        output res_zero, res_ovf,
`endif
        output result, busy, done, div_err
    );

endinterface

// File: rtl/iter_counter_2bit.sv
// Iteration counter for the four multiply/divide steps; last flags the final step.
module iter_counter_2bit (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= 2'd0;
        end else if (clr) begin
            cnt <= 2'd0;
        end else if (inc) begin
            cnt <= cnt + 2'd1;
        end
    end

    assign last = (cnt == 2'd3);

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequences 4-bit shift-add multiply and restoring divide on the external CPU ALU.
// Defining ALU_MULDIV_FLAGS_EN adds the res_zero/res_ovf result flags.
module alu_muldiv_seq
    import cpu4_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    alu_muldiv_seq_if.slave   bus,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              alu_cout,
    output logic              op_add,
    output logic              op_sub,
    output logic              op_mul,
    output logic              op_div,
    output logic              op_and,
    output logic              alu_lsb,
    output logic [DATA_W-1:0] acc_high_data,
    output logic [DATA_W-1:0] bus_reg_data
);

    state_t            state;
    logic [RES_W-1:0]  acc;
    logic [RES_W-1:0]  acc_nxt;
    logic [RES_W-1:0]  done_val;
    logic [DATA_W-1:0] breg;
    logic              c, c_nxt;
    logic              msb, msb_nxt;
    logic              is_div;
    logic              cnt_clr, cnt_inc, cnt_last;
    logic              div0, enter_done;

    iter_counter_2bit u_iter_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .last    (cnt_last)
    );

    // An iteration ends on SHIFT for multiply and on CALC for divide.
    assign cnt_clr    = (state == ST_LOAD);
    assign cnt_inc    = (state == ST_SHIFT && !is_div) || (state == ST_CALC && is_div);
    assign div0       = (state == ST_LOAD) && (bus.op_sel == OP_DIV) && (bus.operand_b == '0);
    assign enter_done = div0 || (cnt_inc && cnt_last);
    assign done_val   = div0 ? {bus.operand_a, DIV0_QUOT} : acc_nxt;

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches are inferred.
        acc_nxt = acc;
        c_nxt   = c;
        msb_nxt = msb;
        case (state)
            ST_LOAD: acc_nxt = {{DATA_W{1'b0}}, bus.operand_a};
            ST_CALC: begin
                if (!is_div) begin
                    if (acc[0]) begin
                        acc_nxt[RES_W-1:DATA_W] = alu_data;
                        c_nxt                   = alu_cout;
                    end else begin
                        c_nxt = 1'b0;
                    end
                end else if (msb || alu_cout) begin
                    // With msb set the true remainder exceeds 4 bits, so the mod-16 difference is exact.
                    acc_nxt[RES_W-1:DATA_W] = alu_data;
                    acc_nxt[0]              = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!is_div) begin
                    acc_nxt = {c, acc[RES_W-1:1]};
                end else begin
                    {msb_nxt, acc_nxt} = {acc, 1'b0};
                end
            end
            default: ;
        endcase
    end

    assign op_mul        = !is_div && (state == ST_CALC || state == ST_SHIFT);
    assign op_div        =  is_div && (state == ST_CALC || state == ST_SHIFT);
    assign op_add        = op_mul && (state == ST_CALC) && acc[0];
    assign op_sub        = op_div && (state == ST_CALC);
    assign op_and        = 1'b0;
    assign alu_lsb       = acc[0];
    assign acc_high_data = acc[RES_W-1:DATA_W];
    assign bus_reg_data  = breg;

    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            acc         <= '0;
            breg        <= '0;
            c           <= 1'b0;
            msb         <= 1'b0;
            is_div      <= 1'b0;
            bus.result  <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.div_err <= 1'b0;
`ifdef ALU_MULDIV_FLAGS_EN
            bus.res_zero <= 1'b0;
            bus.res_ovf  <= 1'b0;
`endif
        end else begin
            acc      <= acc_nxt;
            c        <= c_nxt;
            msb      <= msb_nxt;
            bus.done <= enter_done;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state       <= ST_LOAD;
                        bus.busy    <= 1'b1;
                        bus.div_err <= 1'b0;
`ifdef ALU_MULDIV_FLAGS_EN
                        bus.res_zero <= 1'b0;
                        bus.res_ovf  <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    breg   <= bus.operand_b;
                    is_div <= (bus.op_sel == OP_DIV);
                    if (div0) begin
                        state <= ST_DONE;
                    end else if (bus.op_sel == OP_MUL) begin
                        state <= ST_CALC;
                    end else begin
                        state <= ST_SHIFT;
                    end
                end
                ST_CALC:  state <= (is_div && cnt_last) ? ST_DONE : ST_SHIFT;
                ST_SHIFT: state <= (!is_div && cnt_last) ? ST_DONE : ST_CALC;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
            if (enter_done) begin
                bus.result  <= done_val;
                bus.busy    <= 1'b0;
                bus.div_err <= div0;
`ifdef ALU_MULDIV_FLAGS_EN
                bus.res_zero <= (done_val == '0);
                bus.res_ovf  <= !div0 && !is_div && (done_val[RES_W-1:DATA_W] != '0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench: sequencer paired with a behavioural 4-bit ALU, hand-computed expectations.
module tb_alu_muldiv_seq;
    import cpu4_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] alu_data;
    logic       alu_cout;
    logic       op_add, op_sub, op_mul, op_div, op_and, alu_lsb;
    logic [3:0] acc_high_data, bus_reg_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq_if bus ();

    alu_muldiv_seq dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .alu_data      (alu_data),
        .alu_cout      (alu_cout),
        .op_add        (op_add),
        .op_sub        (op_sub),
        .op_mul        (op_mul),
        .op_div        (op_div),
        .op_and        (op_and),
        .alu_lsb       (alu_lsb),
        .acc_high_data (acc_high_data),
        .bus_reg_data  (bus_reg_data)
    );

    // 4-bit CPU ALU: add with carry-out, subtract with cout=1 meaning no borrow.
    always_comb begin
        alu_data = acc_high_data;
        alu_cout = 1'b0;
        if (op_add) begin
            {alu_cout, alu_data} = {1'b0, acc_high_data} + {1'b0, bus_reg_data};
        end else if (op_sub) begin
            alu_data = acc_high_data - bus_reg_data;
            alu_cout = (acc_high_data >= bus_reg_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE; lat counts cycles from the start edge to the done cycle.
    task automatic run_op(input logic sel, input logic [3:0] a, input logic [3:0] b,
                          input int p1, input int p2,
                          output int lat, output int adds,
                          output logic busy_load, output logic err_mid);
        tick();
        bus.start     = 1'b1;
        bus.op_sel    = sel;
        bus.operand_a = a;
        bus.operand_b = b;
        tick();
        bus.start = 1'b0;
        lat       = 1;
        adds      = 0;
        busy_load = bus.busy;
        err_mid   = 1'b0;
        while (!bus.done && lat < 40) begin
            if (op_add) adds++;
            bus.start = (lat == p1) || (lat == p2);
            tick();
            lat++;
            if (lat == 2) err_mid = bus.div_err;
        end
        bus.start = 1'b0;
    endtask

    int   lat, adds, done_cnt;
    logic bl, em;

    initial begin
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.op_sel    = OP_MUL;
        bus.operand_a = 4'h0;
        bus.operand_b = 4'h0;
        #12;
        check("reset_result", bus.result, 8'h00);
        check("reset_ctrl", {bus.busy, bus.done, bus.div_err}, 3'b000);
        check("reset_strobes", {op_add, op_sub, op_mul, op_div, op_and, alu_lsb}, 6'b0);
        check("reset_regs", {acc_high_data, bus_reg_data}, 8'h00);
        reset_n = 1'b1;

        // 6 x 7: multiplier bits 1 and 2 set -> exactly two add cycles.
        run_op(OP_MUL, 4'd6, 4'd7, 0, 0, lat, adds, bl, em);
        check("mul6x7_lat", lat, 10);
        check("mul6x7_res", bus.result, 8'h2A);
        check("mul6x7_err", bus.div_err, 1'b0);
        check("mul6x7_adds", adds, 2);
        check("mul6x7_busy_load", bl, 1'b1);
        check("mul6x7_busy_done", bus.busy, 1'b0);
`ifdef ALU_MULDIV_FLAGS_EN
        check("mul6x7_ovf", bus.res_ovf, 1'b1);
`endif

        // start pulses in cycles 3 and 9 must be ignored.
        run_op(OP_MUL, 4'd6, 4'd7, 3, 9, lat, adds, bl, em);
        check("ign_lat", lat, 10);
        check("ign_res", bus.result, 8'h2A);
        bus.start = 1'b1;          // also pulse during the DONE cycle
        tick();
        bus.start = 1'b0;
        done_cnt  = 0;
        repeat (3) begin
            if (bus.done || bus.busy) done_cnt++;
            tick();
        end
        check("ign_no_restart", done_cnt, 0);
        check("ign_res_hold", bus.result, 8'h2A);

        run_op(OP_MUL, 4'd15, 4'd15, 0, 0, lat, adds, bl, em);
        check("mul15x15_res", bus.result, 8'hE1);
        check("mul15x15_adds", adds, 4);

        run_op(OP_MUL, 4'd0, 4'd9, 0, 0, lat, adds, bl, em);
        check("mul0x9_res", bus.result, 8'h00);
        check("mul0x9_adds", adds, 0);
`ifdef ALU_MULDIV_FLAGS_EN
        check("mul0x9_zero", bus.res_zero, 1'b1);
        check("mul0x9_ovf", bus.res_ovf, 1'b0);
`endif

        run_op(OP_DIV, 4'd13, 4'd3, 0, 0, lat, adds, bl, em);
        check("div13_3_lat", lat, 10);
        check("div13_3_res", bus.result, 8'h14);
        check("div13_3_adds", adds, 0);

        run_op(OP_DIV, 4'd15, 4'd1, 0, 0, lat, adds, bl, em);
        check("div15_1_res", bus.result, 8'h0F);
`ifdef ALU_MULDIV_FLAGS_EN
        check("div15_1_ovf", bus.res_ovf, 1'b0);
`endif

        run_op(OP_DIV, 4'd2, 4'd7, 0, 0, lat, adds, bl, em);
        check("div2_7_res", bus.result, 8'h20);

        run_op(OP_DIV, 4'd9, 4'd0, 0, 0, lat, adds, bl, em);
        check("div9_0_lat", lat, 2);
        check("div9_0_err", bus.div_err, 1'b1);
        check("div9_0_res", bus.result, 8'h9F);
        check("div9_0_busy", bus.busy, 1'b0);

        run_op(OP_DIV, 4'd13, 4'd3, 0, 0, lat, adds, bl, em);
        check("after_div0_err_mid", em, 1'b0);
        check("after_div0_err_done", bus.div_err, 1'b0);
        check("after_div0_res", bus.result, 8'h14);

        // Abort in cycle 5 of a multiply.
        tick();
        bus.start     = 1'b1;
        bus.op_sel    = OP_MUL;
        bus.operand_a = 4'd6;
        bus.operand_b = 4'd7;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        check("abort_busy_before", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort_result", bus.result, 8'h00);
        check("abort_ctrl", {bus.busy, bus.done, bus.div_err}, 3'b000);
        check("abort_strobes", {op_add, op_sub, op_mul, op_div, op_and, alu_lsb}, 6'b0);
        check("abort_regs", {acc_high_data, bus_reg_data}, 8'h00);
        #2;
        reset_n  = 1'b1;
        done_cnt = 0;
        repeat (12) begin
            tick();
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", bus.busy, 1'b0);

        run_op(OP_MUL, 4'd3, 4'd5, 0, 0, lat, adds, bl, em);
        check("mul3x5_lat", lat, 10);
        check("mul3x5_res", bus.result, 8'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Control-side counterpart to the 4-bit CPU ALU.
- Owns the 8-bit accumulator and B register, drives the ALU op strobes, operands and `alu_lsb`, and consumes the ALU's combinational `alu_data`/`cout`.
- Sequences 4-bit unsigned multiply (shift-add) and divide (restoring) over 4 iterations.
- Returns an 8-bit result with a done pulse to the CPU control unit.

Parameters:
- DATA_W, 4, operand width; iteration count equals DATA_W; only 4 is supported and verified.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- op_sel  in  1  0 = multiply, 1 = divide
- operand_a  in  4  multiplier / dividend
- operand_b  in  4  multiplicand / divisor
- alu_data  in  4  ALU result (combinational)
- alu_cout  in  1  ALU carry-out (combinational); 1 on subtract means no borrow
- op_add, op_sub, op_mul, op_div, op_and  out  1 each  ALU op strobes; op_and is tied 0
- alu_lsb  out  1  acc[0]
- acc_high_data  out  4  acc[7:4]
- bus_reg_data  out  4  B register
- result  out  8  mul: product; div: {remainder, quotient}
- busy  out  1  high from LOAD through the last iteration
- done  out  1  one-cycle pulse; result valid from this cycle until the next LOAD
- div_err  out  1  divide by zero; valid with done, held until the next LOAD

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; acc, breg, c, msb, iteration counter cleared.
  - All outputs 0, including result, done, busy and div_err.
- States: IDLE, LOAD, CALC, SHIFT, DONE.
- IDLE:
  - start=1 → LOAD.
  - start is ignored in every other state; no queuing.
- LOAD:
  - acc<={4'h0, operand_a}; breg<=operand_b; cnt<=0; div_err<=0; busy=1.
  - If op_sel=1 and operand_b==0: div_err<=1, result<={operand_a, 4'hF}, go to DONE.
  - Otherwise multiply → CALC; divide → SHIFT.
- Multiply iteration (CALC then SHIFT):
  - CALC: op_mul=1. op_add=acc[0].
    - If acc[0]=1: acc[7:4]<=alu_data; c<=alu_cout.
    - Else: c<=0.
  - SHIFT: op_mul=1; acc<={c, acc[7:1]}; cnt++.
    - If cnt was 3 → DONE, else → CALC.
- Divide iteration (SHIFT then CALC):
  - SHIFT: op_div=1; {msb, acc}<={acc, 1'b0}.
  - CALC: op_div=1; op_sub=1.
    - If msb|alu_cout: acc[7:4]<=alu_data and acc[0]<=1. A mod-16 result is correct when msb=1.
    - cnt++. If cnt was 3 → DONE, else → SHIFT.
- DONE: result<=acc (unless set by the div-by-zero path); done=1; busy=0 → IDLE.
- Latency: start sampled in IDLE at edge T0; done high in cycle T0+10. Div-by-zero: done in cycle T0+2.
- Op strobes are 0 in IDLE, LOAD and DONE. alu_lsb, acc_high_data and bus_reg_data always reflect the registers.
- Arithmetic: unsigned only. The product always fits 8 bits. Quotient ≤ 15; remainder < divisor.
- Reset mid-operation: immediate abort to IDLE; no done pulse is produced.
- start asserted in the DONE cycle is ignored; it must be re-asserted in IDLE.

Optional Feature:
- Macro ALU_MULDIV_FLAGS_EN.
- Defined: adds outputs res_zero and res_ovf, both registered at DONE and cleared at LOAD.
  - res_zero = (result==0).
  - res_ovf = mul and result[7:4]!=0, i.e. the product exceeds 4 bits; always 0 for divide.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `cpu4_pkg`:
  - state encoding constants (IDLE..DONE);
  - OP_MUL=1'b0 and OP_DIV=1'b1;
  - DIV0_QUOT=4'hF.
- One natural sub-module: `iter_counter_2bit`, a cnt with clear/increment and a last flag.
- Datapath and FSM stay in the top module.

Test Plan:
- Bench pairs the DUT with the 4-bit ALU. mul 7×6 → done at T0+10, result=8'h2A, div_err=0, op_add asserted in exactly 2 CALC cycles (A=0110: bits 1 and 2 set).
- mul 15×15 → result=8'hE1. mul 0×9 → result=8'h00 (res_zero=1 when ALU_MULDIV_FLAGS_EN).
- div 13÷3 → result=8'h14 (r=1, q=4). div 15÷1 → 8'h0F. div 2÷7 → 8'h20.
- div 9÷0 → done at T0+2, div_err=1, result=8'h9F. Next valid op → div_err cleared at LOAD.
- start pulsed at cycles 3 and 9 during a busy mul → ignored, a single done pulse, result unchanged.
- reset_n low at cycle 5 of an op → all outputs 0 asynchronously, no done pulse. A fresh 3×5 afterwards → 8'h0F.
